// File: rtl/cpu_defs.sv
// Shared CPU definitions: PC-select encodings, the zero register index and
// the default multiply/divide occupancy latency.
package cpu_defs;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MD_LATENCY_DEFAULT = 32;
    localparam int MD_CNT_W           = 6;

    // True when a source register matches a producer and is not $0.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy down-counter for the multi-cycle HI/LO unit; busy while the
// count is nonzero, reloaded whenever a mult/div sits in EX.
module md_busy_tracker
    import cpu_defs::*;
#(
    parameter int LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(LATENCY);

    logic [MD_CNT_W-1:0] md_cnt_r;

    // Reload on every mult/div entering EX, even on a branch-flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_r <= 6'd0;
        end else if (start) begin
            md_cnt_r <= LOAD_VAL;
        end else if (md_cnt_r != 6'd0) begin
            md_cnt_r <= md_cnt_r - 6'd1;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    assign busy = (md_cnt_r != 6'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use, jr and HI/LO interlocks plus
// branch/jump flushes. HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_unit
    import cpu_defs::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        ID_UsesRt,
    input  logic [2:0]  ID_PCSrc,
    input  logic        ID_MD_Use,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_RegWrite,
    input  logic [4:0]  ID_EX_AddrC,
    input  logic        ID_EX_MDStart,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_AddrC,
    input  logic        EX_BranchTaken,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount,
`endif
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MD_Busy
);

    logic load_use_s;
    logic jr_hazard_s;
    logic md_hazard_s;
    logic stall_s;
    logic jump_s;

    md_busy_tracker #(
        .LATENCY (MD_LATENCY)
    ) u_md_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ID_EX_MDStart),
        .busy  (MD_Busy)
    );

    assign load_use_s = ID_EX_MemRead &&
                        (reg_match(IF_ID_Rs, ID_EX_AddrC) ||
                         (ID_UsesRt && reg_match(IF_ID_Rt, ID_EX_AddrC)));

    assign jr_hazard_s = (ID_PCSrc == PCSRC_JR) && (IF_ID_Rs != REG_ZERO) &&
                         ((ID_EX_RegWrite && (ID_EX_AddrC == IF_ID_Rs)) ||
                          (EX_MEM_MemRead && (EX_MEM_AddrC == IF_ID_Rs)));

    assign md_hazard_s = ID_MD_Use && (MD_Busy || ID_EX_MDStart);

    assign stall_s = load_use_s || jr_hazard_s || md_hazard_s;

    assign jump_s = (ID_PCSrc == PCSRC_J) ||
                    ((ID_PCSrc == PCSRC_JR) && !jr_hazard_s);

    // Output priority: taken branch, then stall, then jump redirect. A jump
    // held by a stall must not flush itself out of IF/ID.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall_s) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (jump_s) begin
            IF_ID_Flush = 1'b1;
        end else begin
            IF_ID_Flush = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_r;
    logic [31:0] flush_count_r;

    // Event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= 32'd0;
            flush_count_r <= 32'd0;
        end else begin
            if (stall_s && !EX_BranchTaken) begin
                stall_count_r <= stall_count_r + 32'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (IF_ID_Flush) begin
                flush_count_r <= flush_count_r + 32'd1;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign StallCount = stall_count_r;
    assign FlushCount = flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a vector table for the combinational hazard
// terms plus hand-written multi-cycle sequences (load-use, jr, MD, reset).
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_AddrC, EX_MEM_AddrC;
    logic        ID_UsesRt, ID_MD_Use, ID_EX_MemRead, ID_EX_RegWrite;
    logic        ID_EX_MDStart, EX_MEM_MemRead, EX_BranchTaken;
    logic [2:0]  ID_PCSrc;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCount, FlushCount;
    logic [31:0] stall_snap, flush_snap;
`endif

    int checks = 0;
    int failures = 0;

    hazard_unit #(.MD_LATENCY(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_PCSrc       (ID_PCSrc),
        .ID_MD_Use      (ID_MD_Use),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_AddrC    (ID_EX_AddrC),
        .ID_EX_MDStart  (ID_EX_MDStart),
        .EX_MEM_MemRead (EX_MEM_MemRead),
        .EX_MEM_AddrC   (EX_MEM_AddrC),
        .EX_BranchTaken (EX_BranchTaken),
`ifdef HAZARD_PERF_CNT_EN
        .StallCount     (StallCount),
        .FlushCount     (FlushCount),
`endif
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .MD_Busy        (MD_Busy)
    );

    always #5 clk = ~clk;

    // exp = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [2:0] pcsrc;
        logic       md_use;
        logic       ex_rd;
        logic       ex_rw;
        logic [4:0] ex_c;
        logic       mem_rd;
        logic [4:0] mem_c;
        logic       br;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [3:0] outs();
        return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_PCSrc = 3'b000;
        ID_MD_Use = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0;
        ID_EX_AddrC = 5'd0; ID_EX_MDStart = 1'b0; EX_MEM_MemRead = 1'b0;
        EX_MEM_AddrC = 5'd0; EX_BranchTaken = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        IF_ID_Rs = v.rs; IF_ID_Rt = v.rt; ID_UsesRt = v.uses_rt; ID_PCSrc = v.pcsrc;
        ID_MD_Use = v.md_use; ID_EX_MemRead = v.ex_rd; ID_EX_RegWrite = v.ex_rw;
        ID_EX_AddrC = v.ex_c; ID_EX_MDStart = 1'b0; EX_MEM_MemRead = v.mem_rd;
        EX_MEM_AddrC = v.mem_c; EX_BranchTaken = v.br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          name            rs     rt     urt   pcsrc   md    exrd  exrw  exc    memrd memc   br    exp
        vecs[0]  = '{"idle",        5'd0,  5'd0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[1]  = '{"lu_rs",       5'd5,  5'd0,  1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 4'b0001};
        vecs[2]  = '{"lu_rt",       5'd1,  5'd5,  1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 4'b0001};
        vecs[3]  = '{"lu_rt_unused",5'd1,  5'd5,  1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[4]  = '{"lu_zero_rs",  5'd0,  5'd3,  1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[5]  = '{"lu_zero_rt",  5'd0,  5'd0,  1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[6]  = '{"alu_fwd",     5'd5,  5'd0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[7]  = '{"jr_ex_alu",   5'd5,  5'd0,  1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 4'b0001};
        vecs[8]  = '{"jr_mem_load", 5'd5,  5'd0,  1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b0, 4'b0001};
        vecs[9]  = '{"jr_free",     5'd5,  5'd0,  1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 5'd7,  1'b0, 4'b1110};
        vecs[10] = '{"j",           5'd0,  5'd0,  1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b1110};
        vecs[11] = '{"jr_zero",     5'd0,  5'd0,  1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 4'b1110};
        vecs[12] = '{"br_over_lu",  5'd5,  5'd0,  1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 4'b1111};
        vecs[13] = '{"br_alone",    5'd0,  5'd0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 4'b1111};
        vecs[14] = '{"md_idle",     5'd0,  5'd0,  1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'b1100};
        vecs[15] = '{"mem_ld_nojr", 5'd5,  5'd0,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5,  1'b0, 4'b1100};

        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("reset_outs", 32'(outs()), 32'h0000000C);
        check("reset_busy", 32'(MD_Busy), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset_stallcnt", StallCount, 32'd0);
        check("reset_flushcnt", FlushCount, 32'd0);
`endif
        #10 rst_n = 1'b1;

        // Table of single-cycle hazard conditions, counter idle.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            apply(vecs[i]);
            #2;
            check(vecs[i].name, 32'({outs(), MD_Busy}), 32'({vecs[i].exp, 1'b0}));
        end

        // Load-use: one bubble then release once EX holds the bubble.
        next_cycle();
        clear_inputs();
        IF_ID_Rs = 5'd5; ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_AddrC = 5'd5;
        #2 check("lu_seq_c1", 32'(outs()), 32'h1);
        next_cycle();
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_AddrC = 5'd0;
        EX_MEM_MemRead = 1'b1; EX_MEM_AddrC = 5'd5;
        #2 check("lu_seq_c2", 32'(outs()), 32'hC);

        // jr behind a load: EX match, MEM match, then the jump redirects.
        next_cycle();
        clear_inputs();
        IF_ID_Rs = 5'd31; ID_PCSrc = 3'b011;
        ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_AddrC = 5'd31;
        #2 check("jr_seq_c1", 32'(outs()), 32'h1);
        next_cycle();
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_AddrC = 5'd0;
        EX_MEM_MemRead = 1'b1; EX_MEM_AddrC = 5'd31;
        #2 check("jr_seq_c2", 32'(outs()), 32'h1);
        next_cycle();
        EX_MEM_MemRead = 1'b0; EX_MEM_AddrC = 5'd0;
        #2 check("jr_seq_c3", 32'(outs()), 32'hE);
        next_cycle();
        clear_inputs();
        #2 check("jr_seq_c4", 32'(outs()), 32'hC);

        // MD with latency 4: 5 stall cycles, busy for cycles 2..5.
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            else begin
                next_cycle();
                clear_inputs();
            end
            ID_MD_Use = 1'b1;
            ID_EX_MDStart = (c == 1) ? 1'b1 : 1'b0;
            #2;
            check($sformatf("md_stall_c%0d", c), 32'(outs()), (c <= 5) ? 32'h1 : 32'hC);
            check($sformatf("md_busy_c%0d", c), 32'(MD_Busy), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
        end

        // Branch over a load-use stall; stall counter must not move.
        next_cycle();
        clear_inputs();
        IF_ID_Rs = 5'd9; ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_AddrC = 5'd9;
        EX_BranchTaken = 1'b1;
        #2 check("br_lu_outs", 32'(outs()), 32'hF);
`ifdef HAZARD_PERF_CNT_EN
        stall_snap = StallCount;
        flush_snap = FlushCount;
`endif
        next_cycle();
        clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
        check("br_lu_stallcnt", StallCount, stall_snap);
        check("br_lu_flushcnt", FlushCount, flush_snap + 32'd1);
`endif

        // A mult/div in EX survives a branch flush: counter still loads.
        ID_EX_MDStart = 1'b1; EX_BranchTaken = 1'b1;
        #2 check("br_md_outs", 32'(outs()), 32'hF);
        next_cycle();
        clear_inputs();
        #2 check("br_md_busy", 32'(MD_Busy), 32'd1);
        for (int c = 0; c < 4; c++) next_cycle();
        #2 check("br_md_drained", 32'(MD_Busy), 32'd0);

        // Reset mid-MD at md_cnt=3: busy and stall drop at once.
        next_cycle();
        ID_EX_MDStart = 1'b1;
        next_cycle();
        ID_EX_MDStart = 1'b0;
        next_cycle();
        ID_MD_Use = 1'b1;
        #1 check("rst_md_pre", 32'({outs(), MD_Busy}), 32'h3);
        rst_n = 1'b0;
        #1 check("rst_md_busy", 32'(MD_Busy), 32'd0);
        check("rst_md_outs", 32'(outs()), 32'hC);
        #1 rst_n = 1'b1;
        next_cycle();
        #2 check("rst_md_after", 32'({outs(), MD_Busy}), 32'h18);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush controller for the 5-stage pipelined CPU: it handles every data dependency the forwarding network cannot resolve. It freezes PC and IF/ID, injects bubbles into ID/EX, and flushes wrong-path instructions after taken branches and jumps. It also tracks occupancy of the multi-cycle multiply/divide unit with an internal down-counter.

## Interface
Parameters:
- MD_LATENCY, 32: cycles the HI/LO unit stays busy after a mult/div enters EX; legal range 1..63.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- IF_ID_Rs  input  5  rs of the instruction in ID
- IF_ID_Rt  input  5  rt of the instruction in ID
- ID_UsesRt  input  1  ID instruction reads rt as a source
- ID_PCSrc  input  3  PC select decoded in ID; 3'b010 = j/jal, 3'b011 = jr/jalr
- ID_MD_Use  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegWrite  input  1  instruction in EX writes a register
- ID_EX_AddrC  input  5  destination register of EX instruction
- ID_EX_MDStart  input  1  instruction in EX is mult/div
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_AddrC  input  5  destination register of MEM instruction
- EX_BranchTaken  input  1  conditional branch in EX resolved taken
- PC_Write  output  1  PC load enable
- IF_ID_Write  output  1  IF/ID register load enable
- IF_ID_Flush  output  1  IF/ID register cleared to nop
- ID_EX_Flush  output  1  ID/EX control cleared (bubble)
- MD_Busy  output  1  multiply/divide unit occupied

## Operation
- Hazard terms are combinational. Register $0 never causes a hazard.
- load_use: ID_EX_MemRead && ID_EX_AddrC!=0 && (ID_EX_AddrC==IF_ID_Rs || (ID_UsesRt && ID_EX_AddrC==IF_ID_Rt)).
- jr_hazard: ID_PCSrc==3'b011 && IF_ID_Rs!=0, and either
  - ID_EX_RegWrite && ID_EX_AddrC==IF_ID_Rs, or
  - EX_MEM_MemRead && EX_MEM_AddrC==IF_ID_Rs.
- md_hazard: ID_MD_Use && (MD_Busy || ID_EX_MDStart).
- stall = load_use || jr_hazard || md_hazard.
- When stall is high: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
- Jump resolved in ID (ID_PCSrc is 3'b010, or 3'b011 without jr_hazard): IF_ID_Flush=1.
- EX_BranchTaken has highest priority:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
  - Any stall is cancelled, because the stalled ID instruction is wrong-path.
- MD counter md_cnt, 6 bits:
  - Loads MD_LATENCY on a clock edge where ID_EX_MDStart=1; otherwise decrements while nonzero.
  - MD_Busy = (md_cnt!=0).
  - An MD instruction already in EX is never cancelled by a branch flush; the counter still loads.

## Timing
- Reset (rst_n low, asynchronous): md_cnt=0, MD_Busy=0, perf counters=0. With all hazard inputs low, outputs are PC_Write=1, IF_ID_Write=1, both flushes 0.
- Stall and flush outputs are valid in the same cycle as their inputs; no registered latency.
- Load-use: exactly 1 bubble cycle.
- jr dependent on an EX ALU result: 1 stall. jr dependent on an EX load: 2 stalls (the EX-stage match, then the MEM-stage load match).
- MD: an ID MD instruction behind a mult/div in EX stalls for MD_LATENCY+1 cycles; it proceeds in the cycle where md_cnt reaches 0.
- Reset asserted mid-stall: the counter clears immediately and the stall ends in the same cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output ports
  - StallCount (32 bits): +1 per cycle with stall && !EX_BranchTaken.
  - FlushCount (32 bits): +1 per cycle with IF_ID_Flush.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package/header cpu_defs holds:
  - the PCSRC_* encodings (PCSRC_J=3'b010, PCSRC_JR=3'b011);
  - REG_ZERO=5'd0;
  - the MD_LATENCY default.
- Sub-module md_busy_tracker owns md_cnt and MD_Busy. Its ports are clk, rst_n, start, busy.
- The rest is flat combinational logic plus the optional counters.

## Test plan
- Load-use: EX = lw $5 (ID_EX_MemRead=1, AddrC=5), ID = add rs=5 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; released the next cycle.
- Zero register: EX = lw $0, ID rs=0 -> no stall.
- jr: EX = lw $31, ID = jr $31 -> 2 stall cycles, then IF_ID_Flush=1 for 1 cycle.
- MD, with MD_LATENCY=4: mult in EX, mflo in ID -> stall for 5 cycles, MD_Busy high for 4 cycles, mflo proceeds in cycle 6.
- Branch priority: EX_BranchTaken=1 together with a load_use condition -> PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; with HAZARD_PERF_CNT_EN, StallCount is unchanged.
- Reset mid-MD: md_cnt=3, rst_n pulsed low -> MD_Busy=0 immediately, no stall.
